// File: rtl/regincr_sched_pkg.sv
// Shared types and constants for the round-robin scheduled +1 incrementer.
package regincr_sched_pkg;

  localparam int unsigned DEF_NBITS = 8;
  localparam int unsigned DEF_CBITS = 3;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Request message is {count, data}: data occupies the low NBITS bits.
  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned count_lsb(input int unsigned nbits);
    return nbits;
  endfunction

endpackage

// File: rtl/regincr_dp.sv
// Working register with parallel load and +1 increment (modulo 2^NBITS).
module regincr_dp
  import regincr_sched_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             incr,
  input  logic [NBITS-1:0] load_data,
  output logic [NBITS-1:0] out
);

  logic [NBITS-1:0] work_q;

  // Load has priority; the two are never requested together by the scheduler.
  always_ff @(posedge clk) begin
    if (reset)     work_q <= '0;
    else if (load) work_q <= load_data;
    else if (incr) work_q <= work_q + NBITS'(1);
  end

  assign out = work_q;

endmodule

// File: rtl/regincr_rr_sched.sv
// Two requesters share one registered incrementer; round-robin grant,
// one transaction in flight, response routed back to the originator.
module regincr_rr_sched
  import regincr_sched_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS,
  parameter int unsigned CBITS = DEF_CBITS
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   req0_val,
  output logic                   req0_rdy,
  input  logic [CBITS+NBITS-1:0] req0_msg,
  output logic                   resp0_val,
  input  logic                   resp0_rdy,
  output logic [NBITS-1:0]       resp0_msg,

  input  logic                   req1_val,
  output logic                   req1_rdy,
  input  logic [CBITS+NBITS-1:0] req1_msg,
  output logic                   resp1_val,
  input  logic                   resp1_rdy,
  output logic [NBITS-1:0]       resp1_msg
);

  localparam int unsigned MBITS   = CBITS + NBITS;
  localparam int unsigned CNT_LSB = count_lsb(NBITS);

  state_t           state_q, state_d;
  logic [CBITS-1:0] counter_q;
  logic             owner_q;
  logic             rr_ptr_q;

  logic             grant;
  logic [MBITS-1:0] grant_msg;
  logic [NBITS-1:0] grant_data;
  logic [CBITS-1:0] grant_cnt;
  logic             fire;
  logic             resp_ack;
  logic [NBITS-1:0] work;

  // Arbitration: a lone requester wins, the pointer breaks ties.
  always_comb begin
    grant = REQ0;
    if (req0_val && req1_val) grant = rr_ptr_q;
    else if (req1_val)        grant = REQ1;
    grant_msg  = (grant == REQ1) ? req1_msg : req0_msg;
    grant_data = grant_msg[DATA_LSB +: NBITS];
    grant_cnt  = grant_msg[CNT_LSB +: CBITS];
    resp_ack   = (owner_q == REQ1) ? resp1_rdy : resp0_rdy;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; everything is forced low while in reset.
  always_comb begin
    state_d   = state_q;
    fire      = 1'b0;
    req0_rdy  = 1'b0;
    req1_rdy  = 1'b0;
    resp0_val = 1'b0;
    resp1_val = 1'b0;
    resp0_msg = '0;
    resp1_msg = '0;
    case (state_q)
      IDLE: begin
        if (!reset) begin
          req0_rdy = req0_val && (grant == REQ0);
          req1_rdy = req1_val && (grant == REQ1);
          fire     = req0_val || req1_val;
        end
        if (fire) state_d = (grant_cnt != '0) ? CALC : DONE;
      end
      CALC: begin
        if (counter_q == CBITS'(1)) state_d = DONE;
      end
      DONE: begin
        if (!reset) begin
          resp0_val = (owner_q == REQ0);
          resp1_val = (owner_q == REQ1);
          resp0_msg = (owner_q == REQ0) ? work : '0;
          resp1_msg = (owner_q == REQ1) ? work : '0;
        end
        if (resp_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      owner_q   <= REQ0;
      rr_ptr_q  <= REQ0;
    end else if (fire) begin
      counter_q <= grant_cnt;
      owner_q   <= grant;
      rr_ptr_q  <= ~grant;
    end else if (state_q == CALC) begin
      counter_q <= counter_q - CBITS'(1);
    end
  end

  regincr_dp #(.NBITS(NBITS)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (fire),
    .incr      (state_q == CALC),
    .load_data (grant_data),
    .out       (work)
  );

endmodule

// File: tb/tb_regincr_rr_sched.sv
// Scenario bench for regincr_rr_sched with per-port response scoreboards.
module tb_regincr_rr_sched;

  localparam int unsigned NB = 8;
  localparam int unsigned CB = 3;
  localparam int unsigned MB = CB + NB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_val = 1'b0, req1_val = 1'b0;
  logic          req0_rdy, req1_rdy;
  logic [MB-1:0] req0_msg = '0, req1_msg = '0;
  logic          resp0_val, resp1_val;
  logic          resp0_rdy = 1'b1, resp1_rdy = 1'b1;
  logic [NB-1:0] resp0_msg, resp1_msg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NB-1:0] exp0_q[$], exp1_q[$];
  logic [NB-1:0] got0_q[$], got1_q[$];
  int            grant_log[$];
  int            resp0_cnt = 0, resp1_cnt = 0;
  bit            both_seen = 1'b0;

  always #5 clk = ~clk;

  regincr_rr_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req0_val  (req0_val),
    .req0_rdy  (req0_rdy),
    .req0_msg  (req0_msg),
    .resp0_val (resp0_val),
    .resp0_rdy (resp0_rdy),
    .resp0_msg (resp0_msg),
    .req1_val  (req1_val),
    .req1_rdy  (req1_rdy),
    .req1_msg  (req1_msg),
    .resp1_val (resp1_val),
    .resp1_rdy (resp1_rdy),
    .resp1_msg (resp1_msg)
  );

  // Observation log: grants and accepted responses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_val && req0_rdy) grant_log.push_back(0);
      if (req1_val && req1_rdy) grant_log.push_back(1);
      if (resp0_val && resp0_rdy) begin got0_q.push_back(resp0_msg); resp0_cnt++; end
      if (resp1_val && resp1_rdy) begin got1_q.push_back(resp1_msg); resp1_cnt++; end
      if (resp0_val && resp1_val) both_seen = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  function automatic logic [NB-1:0] ref_incr(input logic [MB-1:0] msg);
    logic [NB-1:0] d;
    d = msg[NB-1:0];
    for (int i = 0; i < int'(msg[MB-1:NB]); i++) d = d + 8'd1;
    return d;
  endfunction

  // Presents one request until accepted; returns at posedge+1 after the fire edge.
  task automatic present(input int p, input logic [MB-1:0] msg, output bit ok);
    ok = 1'b0;
    if (p == 0) begin req0_val = 1'b1; req0_msg = msg; end
    else        begin req1_val = 1'b1; req1_msg = msg; end
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = (p == 0) ? (req0_val && req0_rdy) : (req1_val && req1_rdy);
      @(posedge clk); #1;
    end
    if (p == 0) req0_val = 1'b0; else req1_val = 1'b0;
  endtask

  // Cycles from acceptance until resp_val (1 = cycle after accept); -1 on timeout.
  task automatic wait_resp(input int p, output int lat, output bit other_seen);
    lat = -1;
    other_seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (((p == 0) ? resp1_val : resp0_val) === 1'b1) other_seen = 1'b1;
      if (((p == 0) ? resp0_val : resp1_val) === 1'b1) begin lat = n; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_val = 1'b1; req0_msg = {3'd1, 8'h11};
    req1_val = 1'b1; req1_msg = {3'd1, 8'h22};
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if ({req0_rdy, req1_rdy, resp0_val, resp1_val} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_handshake: rdy0/rdy1/val0/val1=%b required 0000",
               {req0_rdy, req1_rdy, resp0_val, resp1_val});
    end
    n_checks++;
    if ({resp0_msg, resp1_msg} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_msgs: got %h required 0000", {resp0_msg, resp1_msg});
    end
    req0_val = 1'b0; req1_val = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req0_rdy, req1_rdy, resp0_val, resp1_val} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: rdy0/rdy1/val0/val1=%b required 0000",
               {req0_rdy, req1_rdy, resp0_val, resp1_val});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit ok, oth;
    int lat;
    exp0_q.push_back(8'h08);
    present(0, {3'd3, 8'h05}, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_accept: req0 not accepted, required accept"); end
    wait_resp(0, lat, oth);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL single_latency: got %0d required 4", lat); end
    n_checks++;
    if (oth) begin n_fail++; $display("FAIL single_routing: resp1_val seen=1 required 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_count();
    bit ok, oth;
    int lat;
    exp1_q.push_back(8'h7A);
    present(1, {3'd0, 8'h7A}, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL zero_accept: req1 not accepted, required accept"); end
    wait_resp(1, lat, oth);
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL zero_latency: got %0d required 1", lat); end
    n_checks++;
    if (oth) begin n_fail++; $display("FAIL zero_routing: resp0_val seen=1 required 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    bit ok, oth;
    int lat;
    exp0_q.push_back(8'h00);
    present(0, {3'd2, 8'hFE}, ok);
    wait_resp(0, lat, oth);
    n_checks++;
    if (!ok || lat != 3) begin
      n_fail++;
      $display("FAIL wrap_latency: accepted=%0d latency=%0d required 1 and 3", ok, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [MB-1:0] m0[4], m1[4];
    int i0 = 0, i1 = 0, cyc = 0, b0, b1;
    bit f0, f1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    grant_log.delete();
    b0 = resp0_cnt;
    b1 = resp1_cnt;
    for (int k = 0; k < 4; k++) begin
      m0[k] = {CB'(k), NB'(8'h10 + k)};
      m1[k] = {CB'(k + 1), NB'(8'hFA + k)};
      exp0_q.push_back(ref_incr(m0[k]));
      exp1_q.push_back(ref_incr(m1[k]));
    end
    while ((resp0_cnt < b0 + 4 || resp1_cnt < b1 + 4) && cyc < 400) begin
      req0_val = (i0 < 4);
      req1_val = (i1 < 4);
      if (i0 < 4) req0_msg = m0[i0];
      if (i1 < 4) req1_msg = m1[i1];
      @(negedge clk);
      f0 = req0_val && req0_rdy;
      f1 = req1_val && req1_rdy;
      @(posedge clk); #1;
      if (f0) i0++;
      if (f1) i1++;
      cyc++;
    end
    req0_val = 1'b0;
    req1_val = 1'b0;
    n_checks++;
    if (cyc >= 400) begin n_fail++; $display("FAIL b2b_timeout: %0d cycles, required < 400", cyc); end
    n_checks++;
    if (grant_log.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_grant_count: got %0d required 8", grant_log.size());
    end
    for (int k = 0; k < grant_log.size() && k < 8; k++) begin
      n_checks++;
      if (grant_log[k] != (k % 2)) begin
        n_fail++;
        $display("FAIL b2b_grant_order[%0d]: got %0d required %0d", k, grant_log[k], k % 2);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, oth;
    int lat;
    resp0_rdy = 1'b0;
    exp0_q.push_back(8'h32);
    present(0, {3'd2, 8'h30}, ok);
    wait_resp(0, lat, oth);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL bp_latency: got %0d required 3", lat); end
    req1_val = 1'b1;
    req1_msg = {3'd0, 8'h44};
    exp1_q.push_back(8'h44);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (resp0_val !== 1'b1 || resp0_msg !== 8'h32) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: val=%b msg=%h required 1 and 32", n, resp0_val, resp0_msg);
      end
      n_checks++;
      if (req1_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: req1_rdy=%b required 0", n, req1_rdy);
      end
    end
    @(posedge clk); #1;
    resp0_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (resp0_val !== 1'b0 || req1_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: resp0_val=%b req1_rdy=%b required 0 and 1", resp0_val, req1_rdy);
    end
    @(posedge clk); #1;
    req1_val = 1'b0;
    wait_resp(1, lat, oth);
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL bp_next_latency: got %0d required 1", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    bit ok, oth, leaked;
    int lat, c0;
    present(0, {3'd7, 8'h01}, ok);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req0_rdy, req1_rdy, resp0_val, resp1_val} !== 4'b0000 ||
        {resp0_msg, resp1_msg} !== 16'h0000) begin
      n_fail++;
      $display("FAIL midop_reset_outputs: flags=%b msgs=%h required 0000 and 0000",
               {req0_rdy, req1_rdy, resp0_val, resp1_val}, {resp0_msg, resp1_msg});
    end
    c0 = resp0_cnt;
    leaked = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (resp0_val === 1'b1) leaked = 1'b1;
    end
    n_checks++;
    if (leaked || resp0_cnt != c0) begin
      n_fail++;
      $display("FAIL midop_dropped: resp0 seen=%0d required 0", leaked);
    end
    @(posedge clk); #1;
    exp1_q.push_back(8'h11);
    present(1, {3'd1, 8'h10}, ok);
    wait_resp(1, lat, oth);
    n_checks++;
    if (!ok || lat != 2) begin
      n_fail++;
      $display("FAIL midop_followup: accepted=%0d latency=%0d required 1 and 2", ok, lat);
    end
    @(posedge clk); #1;
  endtask

  // Drain both scoreboards: every expected response, in port order, nothing extra.
  task automatic test_scoreboard();
    logic [NB-1:0] e;
    while (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      n_checks++;
      if (got0_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_resp0: got none required %h", e);
      end else if (got0_q[0] !== e) begin
        n_fail++;
        $display("FAIL sb_resp0: got %h required %h", got0_q.pop_front(), e);
      end else void'(got0_q.pop_front());
    end
    while (exp1_q.size() > 0) begin
      e = exp1_q.pop_front();
      n_checks++;
      if (got1_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_resp1: got none required %h", e);
      end else if (got1_q[0] !== e) begin
        n_fail++;
        $display("FAIL sb_resp1: got %h required %h", got1_q.pop_front(), e);
      end else void'(got1_q.pop_front());
    end
    n_checks++;
    if (got0_q.size() != 0 || got1_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_extra: leftover resp0=%0d resp1=%0d required 0 and 0",
               got0_q.size(), got1_q.size());
    end
    n_checks++;
    if (both_seen) begin n_fail++; $display("FAIL sb_exclusive: both resp_val high seen=1 required 0"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_count();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
